// File: rtl/dds_phase_gen.sv
`default_nettype none
// ============================================================================
// Module      : dds_phase_gen
// Description : Phase-accumulator DDS core. Steps an ACC_W-bit phase by a
//               tuning word once every DIV enabled clocks and turns the top
//               8 phase bits into a saw, reverse saw, triangle, square or
//               variable-duty pulse sample. New tuning words are held pending
//               and only take over at an accumulator wrap, so frequency
//               changes never cause a phase jump.
//
// Ports       : clk          - system clock
//               reset_n      - asynchronous active-low reset
//               adder_in     - tuning word from the note-to-tuning-word stage
//               adder_load   - one-cycle strobe, captures adder_in
//               enable       - run (1) / freeze (0)
//               wave_sel     - 0 saw, 1 rev saw, 2 tri, 3 square, 4 pulse,
//                              5..7 silence (mid-scale)
//               duty         - pulse threshold for wave_sel = 4
//               phase        - current accumulator value
//               sample       - 8-bit waveform sample
//               sample_valid - one-cycle pulse when sample updates
//               wrap         - one-cycle pulse after an accumulator carry-out
//               load_pending - a captured tuning word is waiting for a wrap
//
// Revision    : 1.0 - initial release
// ============================================================================
module dds_phase_gen #(
  parameter int ACC_W = 32,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [ACC_W-1:0] adder_in,
  input  logic             adder_load,
  input  logic             enable,
  input  logic [2:0]       wave_sel,
  input  logic [7:0]       duty,
  output logic [ACC_W-1:0] phase,
  output logic [7:0]       sample,
  output logic             sample_valid,
  output logic             wrap,
  output logic             load_pending
);

  localparam int             c_CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_DIV_LAST = c_CNT_W'(DIV - 1);

  localparam logic [2:0] c_SEL_SAW  = 3'd0;
  localparam logic [2:0] c_SEL_RSAW = 3'd1;
  localparam logic [2:0] c_SEL_TRI  = 3'd2;
  localparam logic [2:0] c_SEL_SQR  = 3'd3;
  localparam logic [2:0] c_SEL_PULS = 3'd4;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_CNT_W-1:0] div_cnt_q,      div_cnt_d;
  logic [ACC_W-1:0]   phase_q,        phase_d;
  logic [ACC_W-1:0]   active_q,       active_d;
  logic [ACC_W-1:0]   pending_q,      pending_d;
  logic               load_pending_q, load_pending_d;
  logic [7:0]         sample_q,       sample_d;
  logic               tick_q;
  logic               wrap_q;
  logic               sample_valid_q;

  // --------------------------------------------------------------------------
  // Combinational
  // --------------------------------------------------------------------------
  logic             w_tick;
  logic [ACC_W:0]   w_sum;
  logic             w_carry;
  logic             w_apply;
  logic [7:0]       w_p;
  logic [7:0]       w_t;
  logic [7:0]       w_wave;

  always_comb begin
    w_tick  = enable && (div_cnt_q == c_DIV_LAST);
    w_sum   = {1'b0, phase_q} + {1'b0, active_q};
    w_carry = w_sum[ACC_W];
    // A zero active word can never wrap, so a stopped accumulator takes the
    // pending word at the very next tick instead of waiting forever.
    w_apply = w_tick && (w_carry || (active_q == '0));
  end

  // Divider, accumulator and tuning-word bookkeeping
  always_comb begin
    div_cnt_d      = div_cnt_q;
    phase_d        = phase_q;
    active_d       = active_q;
    pending_d      = pending_q;
    load_pending_d = load_pending_q;

    if (enable) begin
      div_cnt_d = w_tick ? '0 : div_cnt_q + c_CNT_W'(1);
    end

    // The step that applies a new word still adds the old one.
    if (w_tick) begin
      phase_d = w_sum[ACC_W-1:0];
    end

    if (adder_load) begin
      pending_d      = adder_in;
      load_pending_d = 1'b1;
    end

    if (w_apply) begin
      // A load landing on the applying tick goes straight to the active word.
      if (adder_load) begin
        active_d = adder_in;
      end else if (load_pending_q) begin
        active_d = pending_q;
      end
      load_pending_d = 1'b0;
    end
  end

  // Waveform shaping from the already-updated phase
  always_comb begin
    w_p = phase_q[ACC_W-1 -: 8];
    w_t = {w_p[6:0], 1'b0};
    case (wave_sel)
      c_SEL_SAW:  w_wave = w_p;
      c_SEL_RSAW: w_wave = ~w_p;
      c_SEL_TRI:  w_wave = w_p[7] ? ~w_t : w_t;
      c_SEL_SQR:  w_wave = w_p[7] ? 8'h00 : 8'hFF;
      c_SEL_PULS: w_wave = (w_p < duty) ? 8'hFF : 8'h00;
      default:    w_wave = 8'h80;
    endcase
    sample_d = tick_q ? w_wave : sample_q;
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q      <= '0;
      phase_q        <= '0;
      active_q       <= '0;
      pending_q      <= '0;
      load_pending_q <= 1'b0;
      sample_q       <= 8'h00;
      tick_q         <= 1'b0;
      wrap_q         <= 1'b0;
      sample_valid_q <= 1'b0;
    end else begin
      div_cnt_q      <= div_cnt_d;
      phase_q        <= phase_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      load_pending_q <= load_pending_d;
      sample_q       <= sample_d;
      // tick_q marks that phase_q was just updated; the sample follows a cycle later.
      tick_q         <= w_tick;
      wrap_q         <= w_tick && w_carry;
      sample_valid_q <= tick_q;
    end
  end

  assign phase        = phase_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign wrap         = wrap_q;
  assign load_pending = load_pending_q;

endmodule
`default_nettype wire

// File: tb/tb_dds_phase_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_dds_phase_gen
// Description : Directed, table-driven bench for dds_phase_gen (DIV=1 and
//               DIV=4 instances sharing the same stimulus).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dds_phase_gen;

  logic        clk;
  logic        reset_n;
  logic [31:0] adder_in;
  logic        adder_load;
  logic        enable;
  logic [2:0]  wave_sel;
  logic [7:0]  duty;

  logic [31:0] phase1, phase4;
  logic [7:0]  sample1, sample4;
  logic        sv1, sv4, wrap1, wrap4, lp1, lp4;

  int checks = 0;
  int errors = 0;

  dds_phase_gen #(.ACC_W(32), .DIV(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .adder_in(adder_in), .adder_load(adder_load),
    .enable(enable), .wave_sel(wave_sel), .duty(duty),
    .phase(phase1), .sample(sample1), .sample_valid(sv1), .wrap(wrap1),
    .load_pending(lp1)
  );

  dds_phase_gen #(.ACC_W(32), .DIV(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .adder_in(adder_in), .adder_load(adder_load),
    .enable(enable), .wave_sel(wave_sel), .duty(duty),
    .phase(phase4), .sample(sample4), .sample_valid(sv4), .wrap(wrap4),
    .load_pending(lp4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] sel;
    logic [7:0] duty;
    logic [7:0] p;
    logic [7:0] exp;
  } wvec_t;

  wvec_t vecs[14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Run until the top phase byte of the DIV=1 instance equals target.
  task automatic wait_p(input string name, input logic [7:0] target);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      if (phase1[31:24] == target) found = 1'b1;
      else step();
    end
    check({name, "_wait"}, {31'd0, found}, 32'd1);
  endtask

  task automatic count_val(input string name, input logic [2:0] sel, input logic [7:0] d,
                           input logic [7:0] val, input int exp);
    int n;
    wave_sel = sel;
    duty     = d;
    step();
    n = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (sv1 && sample1 == val) n++;
    end
    check(name, n, exp);
  endtask

  // Step until wrap1 is seen; report any step that is not the expected delta.
  task automatic run_to_wrap(input string name, input logic [31:0] delta);
    logic        seen;
    logic [31:0] prev;
    int          bad;
    seen = 1'b0;
    bad  = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      prev = phase1;
      step();
      if (phase1 - prev != delta) bad++;
      if (wrap1) seen = 1'b1;
    end
    check({name, "_seen"}, {31'd0, seen}, 32'd1);
    check({name, "_step"}, bad, 0);
  endtask

  initial begin
    vecs[0]  = '{"saw5",     3'd0, 8'd0,  8'd5,   8'd5};
    vecs[1]  = '{"rsaw5",    3'd1, 8'd0,  8'd5,   8'hFA};
    vecs[2]  = '{"tri0",     3'd2, 8'd0,  8'd0,   8'd0};
    vecs[3]  = '{"tri127",   3'd2, 8'd0,  8'd127, 8'd254};
    vecs[4]  = '{"tri128",   3'd2, 8'd0,  8'd128, 8'd255};
    vecs[5]  = '{"tri255",   3'd2, 8'd0,  8'd255, 8'd1};
    vecs[6]  = '{"sq127",    3'd3, 8'd0,  8'd127, 8'hFF};
    vecs[7]  = '{"sq128",    3'd3, 8'd0,  8'd128, 8'h00};
    vecs[8]  = '{"pul63",    3'd4, 8'd64, 8'd63,  8'hFF};
    vecs[9]  = '{"pul64",    3'd4, 8'd64, 8'd64,  8'h00};
    vecs[10] = '{"pul_d0",   3'd4, 8'd0,  8'd0,   8'h00};
    vecs[11] = '{"sil5",     3'd5, 8'd0,  8'd3,   8'h80};
    vecs[12] = '{"sil6",     3'd6, 8'd0,  8'd77,  8'h80};
    vecs[13] = '{"sil7",     3'd7, 8'd0,  8'd200, 8'h80};

    reset_n    = 1'b0;
    adder_in   = '0;
    adder_load = 1'b0;
    enable     = 1'b0;
    wave_sel   = 3'd0;
    duty       = 8'd0;
    step();
    step();
    check("rst_phase",  phase1, 32'd0);
    check("rst_sample", {24'd0, sample1}, 32'd0);
    check("rst_sv",     {31'd0, sv1}, 32'd0);
    check("rst_wrap",   {31'd0, wrap1}, 32'd0);
    check("rst_lp",     {31'd0, lp1}, 32'd0);
    reset_n = 1'b1;

    // ---- start from reset, word loaded while frozen ----
    adder_in   = 32'h0100_0000;
    adder_load = 1'b1;
    step();
    adder_load = 1'b0;
    check("ld_lp",    {31'd0, lp1}, 32'd1);
    check("ld_phase", phase1, 32'd0);
    enable = 1'b1;
    step();
    check("start_add0", phase1, 32'd0);
    check("start_lp",   {31'd0, lp1}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("saw_ph%0d", k), phase1, 32'(k) << 24);
      check($sformatf("saw_s%0d", k), {24'd0, sample1}, 32'(k - 1));
      check($sformatf("saw_v%0d", k), {31'd0, sv1}, 32'd1);
    end
    begin
      int nw;
      int badw;
      nw   = 0;
      badw = 0;
      for (int i = 0; i < 512; i++) begin
        step();
        if (wrap1) begin
          nw++;
          if (phase1 != 32'd0) badw++;
        end
      end
      check("wrap_count", nw, 2);
      check("wrap_phase", badw, 0);
    end

    // ---- waveform table ----
    for (int i = 0; i < 14; i++) begin
      wave_sel = vecs[i].sel;
      duty     = vecs[i].duty;
      wait_p(vecs[i].name, vecs[i].p);
      step();
      check(vecs[i].name, {24'd0, sample1}, {24'd0, vecs[i].exp});
      check({vecs[i].name, "_v"}, {31'd0, sv1}, 32'd1);
    end

    // ---- per-period counts ----
    count_val("sq_ff",    3'd3, 8'd0,  8'hFF, 128);
    count_val("sq_00",    3'd3, 8'd0,  8'h00, 128);
    count_val("pul64_ff", 3'd4, 8'd64, 8'hFF, 64);
    count_val("pul64_00", 3'd4, 8'd64, 8'h00, 192);
    count_val("pul0_00",  3'd4, 8'd0,  8'h00, 256);
    count_val("sil6_80",  3'd6, 8'd0,  8'h80, 256);
    wave_sel = 3'd0;

    // ---- phase-continuous tuning change ----
    begin
      logic found;
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
        if (phase1 == 32'h1000_0000) found = 1'b1;
        else step();
      end
      check("pc_wait", {31'd0, found}, 32'd1);
    end
    adder_in   = 32'h0200_0000;
    adder_load = 1'b1;
    step();
    adder_load = 1'b0;
    check("pc_lp",      {31'd0, lp1}, 32'd1);
    check("pc_oldstep", phase1, 32'h1100_0000);
    run_to_wrap("pc1", 32'h0100_0000);
    check("pc1_phase", phase1, 32'd0);
    check("pc1_lp",    {31'd0, lp1}, 32'd0);
    step();
    check("pc1_new1", phase1, 32'h0200_0000);
    step();
    check("pc1_new2", phase1, 32'h0400_0000);
    // two loads before the wrap: the later one wins
    adder_in   = 32'h0500_0000;
    adder_load = 1'b1;
    step();
    adder_load = 1'b0;
    step();
    adder_in   = 32'h0300_0000;
    adder_load = 1'b1;
    step();
    adder_load = 1'b0;
    check("pc2_lp",  {31'd0, lp1}, 32'd1);
    check("pc2_ph",  phase1, 32'h0A00_0000);
    run_to_wrap("pc2", 32'h0200_0000);
    check("pc2_phase", phase1, 32'd0);
    step();
    check("pc2_new", phase1, 32'h0300_0000);

    // ---- asynchronous reset mid-run ----
    step();
    step();
    enable     = 1'b0;
    adder_in   = 32'h0700_0000;
    adder_load = 1'b1;
    step();
    adder_load = 1'b0;
    check("pre_lp",    {31'd0, lp1}, 32'd1);
    check("pre_phase", phase1, 32'h0900_0000);
    check("pre_samp",  {24'd0, sample1}, 32'd9);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_phase",  phase1, 32'd0);
    check("arst_sample", {24'd0, sample1}, 32'd0);
    check("arst_wrap",   {31'd0, wrap1}, 32'd0);
    check("arst_sv",     {31'd0, sv1}, 32'd0);
    check("arst_lp",     {31'd0, lp1}, 32'd0);
    #1;
    reset_n = 1'b1;

    // ---- same-cycle load on the applying (stopped-start) tick ----
    enable     = 1'b1;
    adder_in   = 32'h0100_0000;
    adder_load = 1'b1;
    step();
    adder_load = 1'b0;
    check("byp_lp",    {31'd0, lp1}, 32'd0);
    check("byp_phase", phase1, 32'd0);
    step();
    check("byp_step1", phase1, 32'h0100_0000);
    step();
    check("byp_step2", phase1, 32'h0200_0000);

    // ---- DIV=4 with enable gaps ----
    enable   = 1'b0;
    wave_sel = 3'd0;
    reset_n  = 1'b0;
    step();
    step();
    reset_n    = 1'b1;
    adder_in   = 32'h0100_0000;
    adder_load = 1'b1;
    step();
    adder_load = 1'b0;
    check("d4_lp", {31'd0, lp4}, 32'd1);
    enable = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      logic [31:0] exp_ph;
      logic        exp_sv;
      step();
      exp_ph = (e / 4 > 1) ? (32'(e / 4 - 1) << 24) : 32'd0;
      exp_sv = (e >= 5) && (e % 4 == 1);
      check($sformatf("d4_ph%0d", e), phase4, exp_ph);
      check($sformatf("d4_sv%0d", e), {31'd0, sv4}, {31'd0, exp_sv});
    end
    step();
    check("d4_s17", {24'd0, sample4}, 32'd3);
    step();
    enable = 1'b0;
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
        step();
        if (phase4 != 32'h0300_0000 || sample4 != 8'd3 || sv4) bad++;
      end
      check("d4_frozen", bad, 0);
    end
    enable = 1'b1;
    step();
    check("d4_r1_ph", phase4, 32'h0300_0000);
    check("d4_r1_sv", {31'd0, sv4}, 32'd0);
    step();
    check("d4_r2_ph", phase4, 32'h0400_0000);
    step();
    check("d4_r3_sv", {31'd0, sv4}, 32'd1);
    check("d4_r3_s",  {24'd0, sample4}, 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dds_phase_gen.md
Name: dds_phase_gen

Overview:
- Phase-accumulator DDS core. Sits directly downstream of the note-to-tuning-word stage and consumes its 32-bit ADDER.
- Produces an 8-bit waveform sample selected from saw, reverse saw, triangle, square or variable-duty pulse.
- Tuning-word changes are deferred to the accumulator wrap, so frequency changes are phase-continuous.

Parameters:
- ACC_W, 32, accumulator and tuning-word width.
- DIV, 1, sample-tick divider: one accumulator step every DIV enabled clocks (DIV >= 1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- adder_in  in  ACC_W  tuning word from the note-to-tuning-word stage.
- adder_load  in  1  one-cycle strobe: capture adder_in.
- enable  in  1  run/freeze.
- wave_sel  in  3  0 saw, 1 reverse saw, 2 triangle, 3 square, 4 pulse, 5-7 silence.
- duty  in  8  pulse threshold for wave_sel=4.
- phase  out  ACC_W  current accumulator value.
- sample  out  8  waveform sample.
- sample_valid  out  1  one-cycle pulse when sample updates.
- wrap  out  1  one-cycle pulse on accumulator carry-out.
- load_pending  out  1  a captured tuning word is waiting for wrap.

Behaviour:
- Reset: asserting reset_n low asynchronously clears the following, regardless of state, including mid-period:
  - phase=0, active word=0, pending word=0, load_pending=0
  - divider=0, sample=8'h00, sample_valid=0, wrap=0
- Divider: when enable=1, the counter runs 0..DIV-1. tick=1 in a cycle where enable=1 and counter==DIV-1; the counter returns to 0 on tick. DIV=1 gives a tick every enabled cycle. When enable=0 the counter holds.
- Accumulator: on a tick clock edge, phase <= phase + active word, mod 2^ACC_W. wrap=1 for the cycle after any tick whose addition carries out; otherwise wrap=0.
- Tuning-word load:
  - adder_load=1 captures adder_in into the pending word and sets load_pending.
  - A second load before apply overwrites the pending word (last wins).
- Apply rule: at a tick that carries out, the active word <= pending word and load_pending clears. The carrying step itself uses the old word; the new word is used from the next tick.
- Stopped start: if active word==0 (no wrap is possible), the pending word is applied at the next tick without a carry. That tick adds 0.
- Same-cycle load and apply (adder_load in the same cycle as an applying tick): adder_in is applied directly, bypassing the pending register, and load_pending ends 0.
- Loads are captured while enable=0. Apply waits for a tick.
- Waveform stage: registered, 1-cycle latency after the phase update. In the cycle after a tick, sample <= f(p) and sample_valid=1, where p = phase[ACC_W-1:ACC_W-8] post-update and t = {p[6:0],1'b0}:
  - saw: p
  - reverse saw: ~p
  - triangle: p[7] ? ~t : t (p=127→254, 128→255, 255→1)
  - square: p<128 ? 8'hFF : 8'h00
  - pulse: p<duty ? 8'hFF : 8'h00 (duty=0 → always 0)
  - silence: 8'h80
- wave_sel and duty are sampled at the waveform register; changes take effect at the next sample.
- Without a tick: sample holds and sample_valid=0.
- enable low: phase, sample and divider freeze. Outputs stay stable.

Test Plan:
- Reset mid-run: reset_n driven low between clock edges with phase≠0 → phase, sample, wrap, sample_valid, load_pending read 0 immediately, without waiting for a clock edge.
- Start from reset, DIV=1, sel=0, load 0x01000000:
  - first tick adds 0; the next ticks give phase 0x01000000, 0x02000000, …
  - sample 1,2,3… each one cycle after the phase update
  - wrap pulses once every 256 ticks
- Phase-continuous change: running at 0x01000000, load 0x02000000 at phase 0x10000000 → load_pending=1, step stays 0x01000000 until wrap, then step 0x02000000 and load_pending=0. A second load 0x03000000 before wrap → 0x03000000 applied instead.
- Triangle/square at 0x01000000:
  - triangle: p=0→0, 127→254, 128→255, 255→1
  - square: 128 samples 0xFF then 128 samples 0x00
- Pulse duty=64 → 64 samples 0xFF, 192 samples 0x00 per period. duty=0 → all 0x00. wave_sel=6 → constant 0x80.
- DIV=4, enable toggled: tick and sample_valid every 4th enabled clock. enable low for 10 cycles → phase/sample frozen, no sample_valid. Resume continues from the held divider count.
